// File: rtl/stream_cipher_wide_pkg.sv
// Shared definitions for the wide Geffe keystream cipher.
//   LMAX          widest LFSR the helper functions handle
//   DEF_TAPS1..3  default feedback masks for the 19/23/25-bit LFSRs
//   key_width()   total key length from the three LFSR lengths
//   geffe()       Geffe combiner: a selects between b and c
//   lfsr_step()   one right shift of a Fibonacci LFSR of length len,
//                 feedback parity injected at bit len-1 together with an extra bit
package stream_cipher_wide_pkg;

    localparam int unsigned LMAX = 32;

    localparam logic [18:0] DEF_TAPS1 = 19'h40027;
    localparam logic [22:0] DEF_TAPS2 = 23'h400011;
    localparam logic [24:0] DEF_TAPS3 = 25'h1000009;

    function automatic int unsigned key_width(input int unsigned l1,
                                              input int unsigned l2,
                                              input int unsigned l3);
        return l1 + l2 + l3;
    endfunction

    function automatic logic geffe(input logic a, input logic b, input logic c);
        return (a & b) ^ (~a & c);
    endfunction

    // s must be zero above bit len-1; the new MSB lands at bit len-1.
    function automatic logic [LMAX-1:0] lfsr_step(input logic [LMAX-1:0] s,
                                                  input logic [LMAX-1:0] taps,
                                                  input int unsigned     len,
                                                  input logic            fb);
        logic fbit;
        fbit = (^(s & taps)) ^ fb;
        return (s >> 1) | ({{(LMAX-1){1'b0}}, fbit} << (len - 1));
    endfunction

endpackage

// File: rtl/stream_cipher_wide_if.sv
// Beat stream bundle for stream_cipher_wide.
//   in_valid/in_ready/in_data     source -> cipher beat handshake
//   out_valid/out_ready/out_data  cipher -> sink beat handshake
//   master: the surrounding source/sink; slave: the cipher.
interface stream_cipher_wide_if #(
    parameter int unsigned DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/stream_cipher_wide_bit_slice.sv
// cipher_bit_slice: one combinational keystream bit step.
//   s1_i/s2_i/s3_i  LFSR states before this step
//   x_i             input data bit
//   dec_i           0 encrypt, 1 decrypt (selects which bit is ciphertext)
//   fb_en_i         fold the ciphertext bit into LFSR1 feedback
//   s1_o/s2_o/s3_o  LFSR states after this step
//   y_o             output data bit (x_i ^ keystream)
module cipher_bit_slice
    import stream_cipher_wide_pkg::*;
#(
    parameter int unsigned    L1    = 19,
    parameter int unsigned    L2    = 23,
    parameter int unsigned    L3    = 25,
    parameter logic [L1-1:0]  TAPS1 = DEF_TAPS1,
    parameter logic [L2-1:0]  TAPS2 = DEF_TAPS2,
    parameter logic [L3-1:0]  TAPS3 = DEF_TAPS3
) (
    input  logic [L1-1:0] s1_i,
    input  logic [L2-1:0] s2_i,
    input  logic [L3-1:0] s3_i,
    input  logic          x_i,
    input  logic          dec_i,
    input  logic          fb_en_i,
    output logic [L1-1:0] s1_o,
    output logic [L2-1:0] s2_o,
    output logic [L3-1:0] s3_o,
    output logic          y_o
);
    logic z;
    logic ct;

    always_comb begin
        z    = geffe(s1_i[0], s2_i[0], s3_i[0]);
        y_o  = x_i ^ z;
        // Ciphertext is the input when decrypting, the output when encrypting.
        ct   = dec_i ? x_i : y_o;
        s1_o = L1'(lfsr_step(LMAX'(s1_i), LMAX'(TAPS1), L1, fb_en_i & ct));
        s2_o = L2'(lfsr_step(LMAX'(s2_i), LMAX'(TAPS2), L2, 1'b0));
        s3_o = L3'(lfsr_step(LMAX'(s3_i), LMAX'(TAPS3), L3, 1'b0));
    end
endmodule

// File: rtl/stream_cipher_wide.sv
// stream_cipher_wide: three-LFSR Geffe keystream cipher, DATA_W bits per beat.
//   clk       rising-edge clock
//   nrst      asynchronous active-low reset
//   key_load  shift key_in into {s1,s2,s3} this cycle
//   key_in    serial key bit, MSB of the KEY_W-bit key first
//   dec       0 encrypt / 1 decrypt, taken with each accepted beat
//   fb_en     ciphertext feedback into LFSR1, taken with each accepted beat
//   bus       beat handshake (slave side), data processed MSB first
module stream_cipher_wide
    import stream_cipher_wide_pkg::*;
#(
    parameter int unsigned    DATA_W = 8,
    parameter int unsigned    L1     = 19,
    parameter int unsigned    L2     = 23,
    parameter int unsigned    L3     = 25,
    parameter logic [L1-1:0]  TAPS1  = DEF_TAPS1,
    parameter logic [L2-1:0]  TAPS2  = DEF_TAPS2,
    parameter logic [L3-1:0]  TAPS3  = DEF_TAPS3
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  key_load,
    input  logic                  key_in,
    input  logic                  dec,
    input  logic                  fb_en,
    stream_cipher_wide_if.slave   bus
);
    localparam int unsigned KEY_W = key_width(L1, L2, L3);
    localparam int unsigned CNT_W = $clog2(KEY_W + 1);

    logic [L1-1:0]     s1_q, s1_d;
    logic [L2-1:0]     s2_q, s2_d;
    logic [L3-1:0]     s3_q, s3_d;
    logic [CNT_W-1:0]  key_cnt_q, key_cnt_d;
    logic              key_load_q;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic              keyed;
    logic              in_ready;
    logic              in_fire;
    logic [KEY_W-1:0]  key_shift;
    logic [CNT_W-1:0]  cnt_base;
    logic [DATA_W-1:0] y_beat;

    // chain[k] is the state after k bit steps of the current beat.
    logic [L1-1:0] chain1 [0:DATA_W];
    logic [L2-1:0] chain2 [0:DATA_W];
    logic [L3-1:0] chain3 [0:DATA_W];

    assign chain1[0] = s1_q;
    assign chain2[0] = s2_q;
    assign chain3[0] = s3_q;

    for (genvar k = 0; k < DATA_W; k++) begin : g_slice
        cipher_bit_slice #(
            .L1    (L1),
            .L2    (L2),
            .L3    (L3),
            .TAPS1 (TAPS1),
            .TAPS2 (TAPS2),
            .TAPS3 (TAPS3)
        ) u_slice (
            .s1_i    (chain1[k]),
            .s2_i    (chain2[k]),
            .s3_i    (chain3[k]),
            .x_i     (bus.in_data[DATA_W-1-k]),
            .dec_i   (dec),
            .fb_en_i (fb_en),
            .s1_o    (chain1[k+1]),
            .s2_o    (chain2[k+1]),
            .s3_o    (chain3[k+1]),
            .y_o     (y_beat[DATA_W-1-k])
        );
    end

    assign keyed    = (key_cnt_q == CNT_W'(KEY_W)) & ~key_load;
    assign in_ready = keyed & ~key_load & (~out_valid_q | bus.out_ready);
    assign in_fire  = bus.in_valid & in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    always_comb begin
        s1_d        = s1_q;
        s2_d        = s2_q;
        s3_d        = s3_q;
        key_cnt_d   = key_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        key_shift   = {s1_q, s2_q, s3_q};
        // First cycle of a load restarts the count before counting this bit.
        cnt_base    = key_load_q ? key_cnt_q : '0;

        if (key_load) begin
            key_shift          = {key_shift[KEY_W-2:0], key_in};
            {s1_d, s2_d, s3_d} = key_shift;
            key_cnt_d          = (cnt_base == CNT_W'(KEY_W)) ? cnt_base
                                                             : cnt_base + 1'b1;
        end else if (in_fire) begin
            s1_d = chain1[DATA_W];
            s2_d = chain2[DATA_W];
            s3_d = chain3[DATA_W];
        end

        if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = y_beat;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            key_cnt_q   <= '0;
            key_load_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            key_cnt_q   <= key_cnt_d;
            key_load_q  <= key_load;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
endmodule

// File: tb/tb_stream_cipher_wide.sv
// Directed/randomised bench for stream_cipher_wide with a bit-serial reference model.
module tb_stream_cipher_wide;
    localparam int unsigned KW = 67;
    localparam logic [18:0] T1 = 19'h40027;
    localparam logic [22:0] T2 = 23'h400011;
    localparam logic [24:0] T3 = 25'h1000009;

    logic clk = 1'b0;
    logic nrst, key_load, key_in, dec, fb_en;

    stream_cipher_wide_if #(.DATA_W(8)) bus ();

    stream_cipher_wide #(.DATA_W(8)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .key_load (key_load),
        .key_in   (key_in),
        .dec      (dec),
        .fb_en    (fb_en),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference state: three LFSRs as plain vectors.
    logic [18:0] m1;
    logic [22:0] m2;
    logic [24:0] m3;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_beat(input logic [7:0] x, input logic d, input logic fb,
                              output logic [7:0] y);
        logic z, ct, f1, f2, f3;
        for (int k = 0; k < 8; k++) begin
            z  = m1[0] ? m2[0] : m3[0];
            y[7-k] = x[7-k] ^ z;
            ct = d ? x[7-k] : y[7-k];
            f1 = (($countones(m1 & T1) % 2) == 1) ^ (fb & ct);
            f2 = ($countones(m2 & T2) % 2) == 1;
            f3 = ($countones(m3 & T3) % 2) == 1;
            m1 = {f1, m1[18:1]};
            m2 = {f2, m2[22:1]};
            m3 = {f3, m3[24:1]};
        end
    endtask

    task automatic drive_key(input logic [KW-1:0] k, input int unsigned nbits);
        logic [KW-1:0] kv;
        for (int unsigned i = 0; i < nbits; i++) begin
            key_load = 1'b1;
            key_in   = k[KW-1-i];
            kv = {m1, m2, m3};
            kv = {kv[KW-2:0], key_in};
            {m1, m2, m3} = kv;
            @(negedge clk);
        end
        key_load = 1'b0;
        key_in   = 1'b0;
        @(negedge clk);
    endtask

    task automatic single_beat(input string tag, input logic [7:0] x, input logic d,
                               input logic fb, output logic [7:0] got);
        logic [7:0] exp;
        bus.in_valid  = 1'b1;
        bus.in_data   = x;
        bus.out_ready = 1'b1;
        dec   = d;
        fb_en = fb;
        #1;
        check({tag, "_in_ready"}, bus.in_ready, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        model_beat(x, d, fb, exp);
        got = bus.out_data;
        check({tag, "_out_valid"}, bus.out_valid, 1'b1);
        check({tag, "_model"}, got, exp);
        @(negedge clk);
        check({tag, "_drained"}, bus.out_valid, 1'b0);
    endtask

    task automatic run_stream(input logic [7:0] src[$], input logic d, output logic [7:0] got[$]);
        logic [7:0] expq[$];
        logic [7:0] y, prev_data;
        logic prev_stall;
        int unsigned idx, cyc;
        idx = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
        got = {};
        dec = d;
        fb_en = 1'b1;
        while ((idx < src.size() || bus.out_valid) && cyc < 2000) begin
            bus.in_valid  = (idx < src.size());
            bus.in_data   = (idx < src.size()) ? src[idx] : 8'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
                check("stall_valid", bus.out_valid, 1'b1);
                check("stall_hold", bus.out_data, prev_data);
            end
            check("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) check("stream_extra_beat", 1'b1, 1'b0);
                else check("stream_data", bus.out_data, expq.pop_front());
                got.push_back(bus.out_data);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (bus.in_valid && bus.in_ready) begin
                model_beat(src[idx], d, 1'b1, y);
                expq.push_back(y);
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("stream_in_time", cyc < 2000, 1'b1);
        check("stream_count", got.size(), src.size());
    endtask

    initial begin
        logic [7:0] y;
        logic [7:0] hold;
        logic [KW-1:0] key;
        logic [7:0] src[$];
        logic [7:0] ct[$];
        logic [7:0] pt[$];

        nrst = 1'b0; key_load = 1'b0; key_in = 1'b0; dec = 1'b0; fb_en = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        m1 = '0; m2 = '0; m3 = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 8'h00);
        check("rst_in_ready", bus.in_ready, 1'b0);
        nrst = 1'b1;
        @(negedge clk);

        // No key loaded: nothing may be accepted.
        bus.in_valid = 1'b1; bus.in_data = 8'h3C; bus.out_ready = 1'b1;
        repeat (3) begin
            #1;
            check("nokey_in_ready", bus.in_ready, 1'b0);
            @(negedge clk);
            check("nokey_out_valid", bus.out_valid, 1'b0);
        end
        bus.in_valid = 1'b0;

        // Key 1: only s3[0] set, keystream 1 on the first bit only.
        key = '0; key[0] = 1'b1;
        drive_key(key, KW);
        single_beat("key1", 8'h00, 1'b0, 1'b0, y);
        check("key1_const", y, 8'h80);

        // All-zero key gives an all-zero keystream for the first beat either way.
        drive_key('0, KW);
        single_beat("zero_fb0", 8'hA5, 1'b0, 1'b0, y);
        check("zero_fb0_const", y, 8'hA5);
        drive_key('0, KW);
        single_beat("zero_fb1", 8'hA5, 1'b0, 1'b1, y);
        check("zero_fb1_const", y, 8'hA5);

        // Partial key load leaves the cipher unkeyed.
        key = {$urandom, $urandom, $urandom};
        drive_key(key, 30);
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        check("partial_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        check("partial_out_valid", bus.out_valid, 1'b0);
        bus.in_valid = 1'b0;

        // Random key, autokey encrypt then decrypt with random sink stalls.
        key = {$urandom, $urandom, $urandom};
        key[0] = 1'b1; key[25] = 1'b1; key[48] = 1'b1;
        for (int i = 0; i < 64; i++) src.push_back(8'($urandom));
        drive_key(key, KW);
        run_stream(src, 1'b0, ct);
        drive_key(key, KW);
        run_stream(ct, 1'b1, pt);
        for (int i = 0; i < 64; i++) begin
            if (i < pt.size()) check("roundtrip", pt[i], src[i]);
        end

        // Key load while an output beat is held must not disturb it.
        drive_key(key, KW);
        bus.in_valid = 1'b1; bus.in_data = 8'($urandom); bus.out_ready = 1'b0;
        dec = 1'b0; fb_en = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        model_beat(bus.in_data, 1'b0, 1'b0, y);
        check("held_model", bus.out_data, y);
        hold = bus.out_data;
        drive_key(~key, KW);
        check("keyload_held_valid", bus.out_valid, 1'b1);
        check("keyload_held_data", bus.out_data, hold);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("keyload_drain", bus.out_valid, 1'b0);

        // Asynchronous reset mid-stream.
        bus.in_valid = 1'b1; bus.in_data = 8'h5A; bus.out_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", bus.out_valid, 1'b1);
        #2 nrst = 1'b0;
        #1;
        check("async_rst_valid", bus.out_valid, 1'b0);
        check("async_rst_ready", bus.in_ready, 1'b0);
        check("async_rst_data", bus.out_data, 8'h00);
        @(negedge clk);
        nrst = 1'b1;
        m1 = '0; m2 = '0; m3 = '0;
        bus.out_ready = 1'b1;
        repeat (3) begin
            #1;
            check("post_rst_ready", bus.in_ready, 1'b0);
            @(negedge clk);
            check("post_rst_valid", bus.out_valid, 1'b0);
        end
        bus.in_valid = 1'b0;
        drive_key(key, KW);
        single_beat("rekey", 8'($urandom), 1'b0, 1'b1, y);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
